// File: rtl/go_pkg.sv
// go_pkg: shared board cell encodings, response codes and board geometry.
package go_pkg;
  localparam int BOARD_SIDE = 8;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;
  localparam logic [1:0] RSP_OK = 2'b00;
  localparam logic [1:0] RSP_OCCUPIED = 2'b01;
  localparam logic [1:0] RSP_BAD_COLOR = 2'b10;
endpackage

// File: rtl/stone_placer_if.sv
// stone_placer_if: move handshake, board RAM port and response pulse.
interface stone_placer_if;
  logic mv_valid;
  logic mv_ready;
  logic [2:0] mv_x;
  logic [2:0] mv_y;
  logic [1:0] mv_color;
  logic [5:0] ram_addr;
  logic ram_we;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;
  logic rsp_valid;
  logic [1:0] rsp_code;
  modport master (
    output mv_valid, mv_x, mv_y, mv_color, ram_rdata,
    input mv_ready, ram_addr, ram_we, ram_wdata, rsp_valid, rsp_code
  );
  modport slave (
    input mv_valid, mv_x, mv_y, mv_color, ram_rdata,
    output mv_ready, ram_addr, ram_we, ram_wdata, rsp_valid, rsp_code
  );
endinterface

// File: rtl/stone_placer.sv
// stone_placer: read-check-write of one board cell per move, with per-colour stone counts.
module stone_placer
  import go_pkg::*;
#(
  parameter int CELLS = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic init_done,
  stone_placer_if.slave bus,
  output logic [6:0] black_cnt,
  output logic [6:0] white_cnt
);
  localparam logic [2:0] IDLE = 3'd0, READ = 3'd1, CHECK = 3'd2, WRITE = 3'd3, RESP = 3'd4;
  localparam logic [6:0] MAX_CNT = 7'(CELLS);
  logic [2:0] state;
  logic [5:0] addr;
  logic [1:0] color;
  logic [1:0] code;
  logic bad;
  assign bad = color != CELL_BLACK && color != CELL_WHITE;
  assign bus.mv_ready = state == IDLE && init_done && !rst;
  assign bus.ram_addr = addr;
  assign bus.ram_we = state == WRITE && init_done;
  assign bus.ram_wdata = state == WRITE ? color : CELL_EMPTY;
  assign bus.rsp_valid = state == RESP && init_done;
  assign bus.rsp_code = code;
  // losing init_done abandons any move in flight; the board is being re-cleared
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr <= '0;
      color <= CELL_EMPTY;
      code <= RSP_OK;
    end else if (!init_done) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (bus.mv_valid && bus.mv_ready) begin
          addr <= {bus.mv_y, bus.mv_x};
          color <= bus.mv_color;
          state <= READ;
        end
        READ: state <= CHECK;
        CHECK: begin
          code <= bad ? RSP_BAD_COLOR : RSP_OCCUPIED;
          state <= (bad || bus.ram_rdata != CELL_EMPTY) ? RESP : WRITE;
        end
        WRITE: begin
          code <= RSP_OK;
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst || !init_done) begin
      black_cnt <= '0;
      white_cnt <= '0;
    end else if (state == WRITE) begin
      black_cnt <= black_cnt + 7'(color == CELL_BLACK && black_cnt < MAX_CNT);
      white_cnt <= white_cnt + 7'(color == CELL_WHITE && white_cnt < MAX_CNT);
    end
  end
endmodule

// File: tb/tb_stone_placer.sv
// tb_stone_placer: directed vector table plus abort, reset and saturation sequences.
module tb_stone_placer;
  import go_pkg::*;
  logic clk = 0, rst = 1, init_done = 0, wipe = 0;
  logic [6:0] black_cnt, white_cnt;
  logic [1:0] mem [64];
  int checks = 0, failures = 0;
  stone_placer_if bus ();
  stone_placer #(.CELLS(64)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .bus(bus),
    .black_cnt(black_cnt), .white_cnt(white_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!init_done || wipe) begin
      for (int i = 0; i < 64; i++) mem[i] <= CELL_EMPTY;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end
  typedef struct {
    logic [2:0] x;
    logic [2:0] y;
    logic [1:0] c;
    logic [1:0] code;
    int rsp_k;
    int we_k;
    int bc;
    int wc;
  } vec_t;
  vec_t tv [6];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_move(input logic [2:0] x, input logic [2:0] y, input logic [1:0] c,
                          input int drop_k, input int rst_k,
                          output int rk, output int wk, output logic [1:0] code,
                          output logic [5:0] ra, output logic [1:0] wd,
                          output int bc, output int wc, output int rdy_ok);
    int np;
    rk = 0; wk = 0; code = 0; ra = 0; wd = 0; bc = -1; wc = -1; np = 0;
    @(negedge clk);
    rdy_ok = int'(bus.mv_ready);
    bus.mv_valid = 1; bus.mv_x = x; bus.mv_y = y; bus.mv_color = c;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.mv_valid = 0;
        ra = bus.ram_addr;
      end
      if (bus.ram_we && wk == 0) begin
        wk = k;
        wd = bus.ram_wdata;
      end
      if (rk == 0 && bus.mv_ready) rdy_ok = 0;
      if (rk != 0 && k == rk + 1 && !bus.mv_ready) rdy_ok = 0;
      if (bus.rsp_valid) begin
        np++;
        if (rk == 0) begin
          rk = k;
          code = bus.rsp_code;
          bc = int'(black_cnt);
          wc = int'(white_cnt);
        end
      end
      if (k == drop_k) init_done = 0;
      if (k == rst_k) rst = 1;
      if (rst_k != 0 && k == rst_k + 1) rst = 0;
    end
    if (np > 1) rdy_ok = 0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int rk, wk, bc, wc, rdy;
    logic [1:0] code, wd;
    logic [5:0] ra, a;
    tv[0] = '{3'd3, 3'd5, CELL_BLACK, RSP_OK, 4, 3, 1, 0};
    tv[1] = '{3'd3, 3'd5, CELL_WHITE, RSP_OCCUPIED, 3, 0, 1, 0};
    tv[2] = '{3'd0, 3'd0, 2'b11, RSP_BAD_COLOR, 3, 0, 1, 0};
    tv[3] = '{3'd3, 3'd5, 2'b00, RSP_BAD_COLOR, 3, 0, 1, 0};
    tv[4] = '{3'd7, 3'd7, CELL_WHITE, RSP_OK, 4, 3, 1, 1};
    tv[5] = '{3'd0, 3'd0, CELL_BLACK, RSP_OK, 4, 3, 2, 1};
    bus.mv_valid = 0; bus.mv_x = 0; bus.mv_y = 0; bus.mv_color = 0;
    repeat (3) @(negedge clk);
    chk("reset_addr", int'(bus.ram_addr), 0);
    chk("reset_rsp_valid", int'(bus.rsp_valid), 0);
    chk("reset_rsp_code", int'(bus.rsp_code), 0);
    rst = 0;
    repeat (2) @(negedge clk);
    chk("no_init_ready", int'(bus.mv_ready), 0);
    chk("no_init_we", int'(bus.ram_we), 0);
    chk("no_init_black", int'(black_cnt), 0);
    chk("no_init_white", int'(white_cnt), 0);
    init_done = 1;
    @(negedge clk);
    chk("init_ready", int'(bus.mv_ready), 1);
    for (int i = 0; i < 6; i++) begin
      run_move(tv[i].x, tv[i].y, tv[i].c, 0, 0, rk, wk, code, ra, wd, bc, wc, rdy);
      chk($sformatf("v%0d_rsp_cycle", i), rk, tv[i].rsp_k);
      chk($sformatf("v%0d_code", i), int'(code), int'(tv[i].code));
      chk($sformatf("v%0d_we_cycle", i), wk, tv[i].we_k);
      chk($sformatf("v%0d_read_addr", i), int'(ra), int'({tv[i].y, tv[i].x}));
      if (tv[i].we_k != 0) chk($sformatf("v%0d_wdata", i), int'(wd), int'(tv[i].c));
      chk($sformatf("v%0d_black", i), bc, tv[i].bc);
      chk($sformatf("v%0d_white", i), wc, tv[i].wc);
      chk($sformatf("v%0d_ready", i), rdy, 1);
    end
    run_move(3'd1, 3'd1, CELL_BLACK, 2, 0, rk, wk, code, ra, wd, bc, wc, rdy);
    chk("drop_rsp", rk, 0);
    chk("drop_we", wk, 0);
    chk("drop_black", int'(black_cnt), 0);
    chk("drop_white", int'(white_cnt), 0);
    chk("drop_ready_low", int'(bus.mv_ready), 0);
    init_done = 1;
    #1;
    chk("drop_idle", int'(bus.mv_ready), 1);
    run_move(3'd2, 3'd2, CELL_BLACK, 0, 1, rk, wk, code, ra, wd, bc, wc, rdy);
    chk("rst_rsp", rk, 0);
    chk("rst_we", wk, 0);
    chk("rst_cell", int'(mem[6'd18]), int'(CELL_EMPTY));
    chk("rst_ready", int'(bus.mv_ready), 1);
    for (int i = 0; i < 64; i++) begin
      a = 6'(i);
      run_move(a[2:0], a[5:3], CELL_BLACK, 0, 0, rk, wk, code, ra, wd, bc, wc, rdy);
      if (code != RSP_OK || rk != 4 || bc != i + 1) chk($sformatf("fill%0d", i), bc, i + 1);
      else checks++;
    end
    chk("full_black", int'(black_cnt), 64);
    run_move(3'd0, 3'd0, CELL_BLACK, 0, 0, rk, wk, code, ra, wd, bc, wc, rdy);
    chk("full_occ_code", int'(code), int'(RSP_OCCUPIED));
    chk("full_occ_black", bc, 64);
    @(negedge clk);
    wipe = 1;
    @(negedge clk);
    wipe = 0;
    run_move(3'd4, 3'd4, CELL_BLACK, 0, 0, rk, wk, code, ra, wd, bc, wc, rdy);
    chk("sat_code", int'(code), int'(RSP_OK));
    chk("sat_we", wk, 3);
    chk("sat_black", bc, 64);
    chk("sat_white", wc, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
